// File: rtl/risc_imm_pkg.sv
// Shared types and the immediate-extraction helper for the decode-path immediate pipe.
package risc_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_BAD = 3'b111
    } imm_src_e;

    localparam int XLEN_MIN = 32;
    localparam int XLEN_MAX = 64;

    // Result is always XLEN_MAX wide and sign-correct; callers keep the low XLEN bits.
    function automatic logic [XLEN_MAX-1:0] imm_extract(input logic [31:0] inst,
                                                        input imm_src_e    src,
                                                        input logic        xlen64);
        logic [XLEN_MAX-1:0] imm;
        imm = '0;
        case (src)
            IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_Z:   imm = {59'b0, inst[19:15]};
            IMM_SH:  imm = xlen64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/risc_imm_slice.sv
// One elastic register slice: loads when empty or when downstream drains it the same edge.
// Held data is frozen while valid and not accepted.
module risc_imm_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/risc_imm_pipe.sv
// Immediate generator plus pc-relative target, followed by STAGES elastic slices.
// A beat accepted at edge N is visible after edge N+STAGES-1; in_ready drops only when every slice is full and stalled.
module risc_imm_pipe
    import risc_imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_imm_src,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_err
);

    if (!(XLEN == XLEN_MIN || XLEN == XLEN_MAX)) begin : g_bad_xlen
        $error("risc_imm_pipe: XLEN must be 32 or 64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("risc_imm_pipe: STAGES must be in 1..4");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            err;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    logic [XLEN_MAX-1:0] imm_full;
    logic                unused_imm;
    beat_t               beat_in;

    logic  vld [STAGES+1];
    logic  rdy [STAGES+1];
    beat_t dat [STAGES+1];

    // Illegal src yields imm 0 from the helper, so target naturally equals pc.
    assign imm_full       = imm_extract(in_inst, imm_src_e'(in_imm_src), XLEN == XLEN_MAX);
    assign unused_imm     = ^imm_full;
    assign beat_in.imm    = imm_full[XLEN-1:0];
    assign beat_in.target = in_pc + imm_full[XLEN-1:0];
    assign beat_in.err    = (imm_src_e'(in_imm_src) == IMM_BAD);

    assign vld[0]      = in_valid;
    assign dat[0]      = beat_in;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        logic [BEAT_W-1:0] q_dat;

        risc_imm_slice #(.W(BEAT_W)) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld[i]),
            .in_ready  (rdy[i]),
            .in_data   (dat[i]),
            .out_valid (vld[i+1]),
            .out_ready (rdy[i+1]),
            .out_data  (q_dat)
        );

        assign dat[i+1] = beat_t'(q_dat);
    end

    assign out_valid  = vld[STAGES];
    assign out_imm    = dat[STAGES].imm;
    assign out_target = dat[STAGES].target;
    assign out_err    = dat[STAGES].err;

endmodule
